// File: rtl/reversi_move_sequencer_if.sv
// Move sequencer bus: game-control request/result plus board read and node write.
// master = control/board side, slave = sequencer.
interface reversi_move_sequencer_if;
  logic       start;
  logic [2:0] row;
  logic [2:0] col;
  logic       set_black;
  logic [5:0] rd_addr;
  logic [2:0] rd_state;
  logic [5:0] wr_addr;
  logic       wr_play;
  logic       wr_reverse;
  logic       wr_black;
  logic       busy;
  logic       done;
  logic       legal;
  logic [5:0] flip_count;

  modport master (
    output start, row, col, set_black, rd_state,
    input  rd_addr, wr_addr, wr_play, wr_reverse, wr_black,
    input  busy, done, legal, flip_count
  );

  modport slave (
    input  start, row, col, set_black, rd_state,
    output rd_addr, wr_addr, wr_play, wr_reverse, wr_black,
    output busy, done, legal, flip_count
  );
endinterface

// File: rtl/reversi_move_sequencer.sv
// Sequences one Reversi move: ENABLE check, 8-ray scan, reverse strobes, place.
// Ports: clk, resetn (async, active-high), bus (request, board read, node write, result).
module reversi_move_sequencer (
  input logic                      clk,
  input logic                      resetn,
  reversi_move_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, CHECK, SCAN, FLIP, NEXT_DIR, PLACE, DONE
  } state_t;

  localparam logic [2:0] S_ENABLE = 3'b100;
  localparam logic [2:0] S_BLACK  = 3'b111;
  localparam logic [2:0] S_WHITE  = 3'b110;

  state_t state, state_nx;

  logic [2:0]        org_r, org_c, dir, run, rem;
  logic              blk, legal_q;
  logic [5:0]        flips;
  logic signed [3:0] cur_r, cur_c;

  function automatic logic signed [3:0] dr_of(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: dr_of = -4'sd1;
      3'd3, 3'd4, 3'd5: dr_of = 4'sd1;
      default:          dr_of = 4'sd0;
    endcase
  endfunction

  function automatic logic signed [3:0] dc_of(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: dc_of = 4'sd1;
      3'd5, 3'd6, 3'd7: dc_of = -4'sd1;
      default:          dc_of = 4'sd0;
    endcase
  endfunction

  logic signed [3:0] o_r, o_c, d_r, d_c;
  logic [2:0]        dir_inc, own, opp;
  logic [5:0]        cur_addr, org_addr;
  logic              oob;

  assign o_r      = $signed({1'b0, org_r});
  assign o_c      = $signed({1'b0, org_c});
  assign d_r      = dr_of(dir);
  assign d_c      = dc_of(dir);
  assign dir_inc  = dir + 3'd1;
  assign own      = blk ? S_BLACK : S_WHITE;
  assign opp      = blk ? S_WHITE : S_BLACK;
  // cursor only ever reaches -1..8, so bit 3 alone flags off-board
  assign oob      = cur_r[3] | cur_c[3];
  assign cur_addr = {cur_r[2:0], cur_c[2:0]};
  assign org_addr = {org_r, org_c};

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.rd_addr    = 6'd0;
    bus.wr_addr    = 6'd0;
    bus.wr_play    = 1'b0;
    bus.wr_reverse = 1'b0;
    bus.wr_black   = 1'b0;
    case (state)
      IDLE:
        if (bus.start) state_nx = CHECK;
      CHECK: begin
        bus.rd_addr = org_addr;
        state_nx = (bus.rd_state == S_ENABLE) ? SCAN : DONE;
      end
      SCAN: begin
        if (oob) begin
          state_nx = NEXT_DIR;
        end else begin
          bus.rd_addr = cur_addr;
          if (bus.rd_state == opp)
            state_nx = SCAN;
          else if (bus.rd_state == own && run != 3'd0)
            state_nx = FLIP;
          else
            state_nx = NEXT_DIR;
        end
      end
      FLIP: begin
        bus.wr_addr    = cur_addr;
        bus.wr_play    = 1'b1;
        bus.wr_reverse = 1'b1;
        if (rem == 3'd1) state_nx = NEXT_DIR;
      end
      NEXT_DIR:
        if (dir != 3'd7)        state_nx = SCAN;
        else if (flips != 6'd0) state_nx = PLACE;
        else                    state_nx = DONE;
      PLACE: begin
        bus.wr_addr  = org_addr;
        bus.wr_play  = 1'b1;
        bus.wr_black = blk;
        state_nx = DONE;
      end
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      org_r   <= 3'd0;
      org_c   <= 3'd0;
      blk     <= 1'b0;
      dir     <= 3'd0;
      run     <= 3'd0;
      rem     <= 3'd0;
      cur_r   <= 4'sd0;
      cur_c   <= 4'sd0;
      flips   <= 6'd0;
      legal_q <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (bus.start) begin
            org_r   <= bus.row;
            org_c   <= bus.col;
            blk     <= bus.set_black;
            flips   <= 6'd0;
            legal_q <= 1'b0;
          end
        CHECK: begin
          dir   <= 3'd0;
          run   <= 3'd0;
          cur_r <= o_r + dr_of(3'd0);
          cur_c <= o_c + dc_of(3'd0);
        end
        SCAN:
          if (!oob && bus.rd_state == opp) begin
            run   <= run + 3'd1;
            cur_r <= cur_r + d_r;
            cur_c <= cur_c + d_c;
          end else if (!oob && bus.rd_state == own && run != 3'd0) begin
            // rewind to the first bracketed cell for the flip pass
            rem   <= run;
            cur_r <= o_r + d_r;
            cur_c <= o_c + d_c;
          end
        FLIP: begin
          flips <= flips + 6'd1;
          rem   <= rem - 3'd1;
          cur_r <= cur_r + d_r;
          cur_c <= cur_c + d_c;
        end
        NEXT_DIR:
          if (dir != 3'd7) begin
            dir   <= dir_inc;
            run   <= 3'd0;
            cur_r <= o_r + dr_of(dir_inc);
            cur_c <= o_c + dc_of(dir_inc);
          end
        PLACE:
          legal_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.legal      = legal_q;
  assign bus.flip_count = flips;
endmodule

// File: tb/tb_reversi_move_sequencer.sv
// Self-checking bench for reversi_move_sequencer: board-rule model plus
// directed moves with hand-computed literals.
module tb_reversi_move_sequencer;
  localparam logic [2:0] EMP = 3'b000;
  localparam logic [2:0] ENA = 3'b100;
  localparam logic [2:0] BLK = 3'b111;
  localparam logic [2:0] WHT = 3'b110;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  reversi_move_sequencer_if bus();

  reversi_move_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  logic [2:0] board [64];
  assign bus.rd_state = board[bus.rd_addr];

  typedef struct {
    logic [5:0] addr;
    logic       rev;
    logic       blk;
  } wr_t;

  wr_t exp_q[$];
  wr_t log_q[$];
  wr_t w, e;
  int  exp_lat, exp_fc, k0, ncnt, meas_lat;
  logic exp_legal;
  bit  active;
  int  tests = 0;
  int  fails = 0;

  int dr[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
  int dc[8] = '{0, 1, 1, 1, 0, -1, -1, -1};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit onb(int r, int c);
    return r >= 0 && r < 8 && c >= 0 && c < 8;
  endfunction

  // Reversi rules applied directly to the board: expected strobes,
  // result and cycle count for one move.
  task automatic model(int orr, int oc, bit b);
    logic [2:0] own, opp;
    int r, c, run;
    own = b ? BLK : WHT;
    opp = b ? WHT : BLK;
    exp_q.delete();
    exp_fc = 0;
    exp_legal = 1'b0;
    exp_lat = 1;
    if (board[orr*8+oc] != ENA) begin
      exp_lat = 2;
      return;
    end
    for (int d = 0; d < 8; d++) begin
      run = 0;
      r = orr + dr[d];
      c = oc + dc[d];
      exp_lat++;
      while (onb(r, c) && board[r*8+c] == opp) begin
        run++;
        r += dr[d];
        c += dc[d];
        exp_lat++;
      end
      if (onb(r, c) && board[r*8+c] == own && run > 0)
        for (int k = 1; k <= run; k++) begin
          exp_q.push_back('{6'((orr + k*dr[d])*8 + oc + k*dc[d]), 1'b1, 1'b0});
          exp_fc++;
          exp_lat++;
        end
      exp_lat++;
    end
    if (exp_fc > 0) begin
      exp_q.push_back('{6'(orr*8 + oc), 1'b0, b});
      exp_legal = 1'b1;
      exp_lat++;
    end
    exp_lat++;
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      active = 0;
      exp_q.delete();
    end else begin
      ncnt++;
      if (active) begin
        if (bus.wr_play) begin
          w = '{bus.wr_addr, bus.wr_reverse, bus.wr_black};
          log_q.push_back(w);
          if (exp_q.size() == 0) begin
            chk("extra_strobe", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_addr", w.addr, e.addr);
            chk("strobe_rev", w.rev, e.rev);
            chk("strobe_blk", w.blk, e.blk);
          end
        end
        if (bus.done) begin
          meas_lat = ncnt - k0;
          chk("latency", meas_lat, exp_lat);
          chk("legal", bus.legal, exp_legal);
          chk("flip_count", bus.flip_count, exp_fc);
          chk("missing_strobes", exp_q.size(), 0);
          active = 0;
        end else if (ncnt - k0 > 400) begin
          chk("done_timeout", 1, 0);
          active = 0;
        end
      end else if (bus.wr_play) begin
        chk("stray_strobe", 1, 0);
      end
      if (!active && bus.start && !bus.busy) begin
        model(int'(bus.row), int'(bus.col), bus.set_black);
        k0 = ncnt;
        active = 1;
        log_q.delete();
      end
    end
  end

  task automatic clear_board();
    foreach (board[i]) board[i] = EMP;
  endtask

  task automatic issue(int r, int c, bit b);
    @(posedge clk); #1;
    bus.row = 3'(r);
    bus.col = 3'(c);
    bus.set_black = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_move(int r, int c, bit b, bit poke);
    int n;
    issue(r, c, b);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    n = 0;
    while (!bus.done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("move_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b1;
    bus.start = 1'b0;
    bus.row = 3'd0;
    bus.col = 3'd0;
    bus.set_black = 1'b0;
    ncnt = 0;
    meas_lat = 0;
    active = 0;
    clear_board();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_legal", bus.legal, 0);
    chk("rst_fc", bus.flip_count, 0);
    chk("rst_play", bus.wr_play, 0);
    chk("rst_rev", bus.wr_reverse, 0);
    chk("rst_blk", bus.wr_black, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    @(posedge clk); #1;
    resetn = 1'b0;

    // origin already BLACK: CHECK, DONE
    board[10] = BLK;
    run_move(1, 2, 1'b1, 1'b0);
    chk("t1_lat", meas_lat, 2);
    chk("t1_legal", bus.legal, 0);
    chk("t1_fc", bus.flip_count, 0);
    chk("t1_strobes", log_q.size(), 0);

    // standard opening, black plays (2,3)
    clear_board();
    board[27] = WHT;
    board[36] = WHT;
    board[28] = BLK;
    board[35] = BLK;
    board[19] = ENA;
    run_move(2, 3, 1'b1, 1'b0);
    chk("t2_lat", meas_lat, 21);
    chk("t2_legal", bus.legal, 1);
    chk("t2_fc", bus.flip_count, 1);
    chk("t2_strobes", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_rev_addr", log_q[0].addr, 27);
      chk("t2_rev_flag", log_q[0].rev, 1);
      chk("t2_play_addr", log_q[1].addr, 19);
      chk("t2_play_blk", log_q[1].blk, 1);
    end

    // corner, six whites along the top edge, start poked while busy
    clear_board();
    board[0] = ENA;
    for (int i = 1; i <= 6; i++) board[i] = WHT;
    board[7] = BLK;
    run_move(0, 0, 1'b1, 1'b1);
    chk("t3_lat", meas_lat, 31);
    chk("t3_fc", bus.flip_count, 6);
    chk("t3_strobes", log_q.size(), 7);
    if (log_q.size() == 7)
      for (int i = 0; i < 6; i++) chk("t3_order", log_q[i].addr, i + 1);

    // east ray bracketed, south ray runs into the edge
    clear_board();
    board[34] = ENA;
    board[35] = WHT;
    board[36] = WHT;
    board[37] = BLK;
    board[42] = WHT;
    board[50] = WHT;
    board[58] = WHT;
    run_move(4, 2, 1'b1, 1'b0);
    chk("t4_fc", bus.flip_count, 2);
    chk("t4_legal", bus.legal, 1);
    chk("t4_strobes", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t4_a0", log_q[0].addr, 35);
      chk("t4_a1", log_q[1].addr, 36);
      chk("t4_a2", log_q[2].addr, 34);
    end

    // ENABLE origin with an unbracketed run
    clear_board();
    board[27] = ENA;
    board[28] = WHT;
    run_move(3, 3, 1'b1, 1'b0);
    chk("t5_lat", meas_lat, 19);
    chk("t5_legal", bus.legal, 0);
    chk("t5_fc", bus.flip_count, 0);
    chk("t5_strobes", log_q.size(), 0);
    chk("t5_busy", bus.busy, 0);

    // reset after the first of three flips
    clear_board();
    board[24] = ENA;
    board[25] = WHT;
    board[26] = WHT;
    board[27] = WHT;
    board[28] = BLK;
    begin
      int n;
      issue(3, 0, 1'b1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.wr_play && n < 200);
      if (n >= 200) chk("t6_flip_timeout", 1, 0);
    end
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("t6_play", bus.wr_play, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_fc", bus.flip_count, 0);
    chk("t6_wr_addr", bus.wr_addr, 0);
    @(posedge clk); #1;
    resetn = 1'b0;
    chk("t6_strobes", log_q.size(), 1);
    run_move(3, 0, 1'b1, 1'b0);
    chk("t6b_fc", bus.flip_count, 3);
    chk("t6b_legal", bus.legal, 1);
    chk("t6b_strobes", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t6b_a0", log_q[0].addr, 25);
      chk("t6b_a3", log_q[3].addr, 24);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reversi_move_sequencer.md
# reversi_move_sequencer

Sequences one Reversi move on the 8x8 board of node-state cells. Given a target square and colour, it checks the square is ENABLE, scans all eight rays for bracketed opponent runs, and issues reverse pulses to every flipped node. It then issues the placing play pulse and reports legality and flip count. It sits between game control and the per-cell node-state controllers, sharing one board read port and one node write strobe.

## Interface

- No parameters; board fixed at 8x8, cell address = row*8+col (6 bits).
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous reset, active-high (asserted = 1).
- start  in  1  one-cycle move request; sampled only when busy=0.
- row, col  in  3 each  target square, row 0 = top, col 0 = left.
- set_black  in  1  mover colour: 1 = BLACK (3'b111), 0 = WHITE (3'b110).
- rd_addr  out  6  board read address.
- rd_state  in  3  state of cell rd_addr, combinational same cycle; EMPTY 000, ENABLE 100, BLACK 111, WHITE 110.
- wr_addr  out  6  node selected for update.
- wr_play  out  1  play strobe to node wr_addr, one cycle per update.
- wr_reverse  out  1  reverse qualifier to node wr_addr.
- wr_black  out  1  set_black to node wr_addr.
- busy  out  1  high from the cycle after start acceptance until DONE exits.
- done  out  1  one-cycle pulse in DONE.
- legal  out  1  move result; valid with done, held until next start.
- flip_count  out  6  total flipped cells; valid with done, held until next start.

## Operation

- States: IDLE, CHECK, SCAN, FLIP, NEXT_DIR, PLACE, DONE.
- IDLE: on start, latch row/col/set_black, clear flip_count and legal, go CHECK.
- CHECK: rd_addr = origin. rd_state != ENABLE goes to DONE with legal=0. Otherwise dir=0, cursor=origin+delta(0), run=0, go SCAN.
- Direction order 0..7: N(-1,0), NE(-1,+1), E(0,+1), SE(+1,+1), S(+1,0), SW(+1,-1), W(0,-1), NW(-1,-1).
- Cursor arithmetic: 4-bit signed per coordinate. Out-of-board means a coordinate is <0 or >7, and out-of-board is tested before any read.
- SCAN, one cell per cycle, rd_addr = cursor:
  - Out-of-board, EMPTY, ENABLE or any undefined code: go NEXT_DIR.
  - Opponent colour: run++, cursor += delta.
  - Own colour with run>0: cursor = origin+delta, remaining = run, go FLIP.
  - Own colour with run=0: go NEXT_DIR.
- FLIP, one cell per cycle, at cursor: wr_play=1, wr_reverse=1, wr_black=0. Then flip_count++, remaining--, cursor += delta. Go NEXT_DIR after the cycle with remaining=1.
- NEXT_DIR (1 cycle, no access): if dir<7 then dir++, cursor=origin+delta, run=0, go SCAN. If dir=7, go PLACE when flip_count>0, else go DONE with legal=0.
- PLACE (1 cycle): wr_addr=origin, wr_play=1, wr_reverse=0, wr_black=set_black; legal=1; go DONE.
- DONE: done=1, go IDLE.
- Rays from one origin are disjoint, so flips made in one direction never affect later scans.
- An illegal move issues no write strobe at all.

## Timing

- Reset values: state IDLE, busy 0, done 0, legal 0, flip_count 0, wr_play 0, wr_reverse 0, wr_black 0, wr_addr 0, rd_addr 0.
- Reset mid-move returns to IDLE immediately; no further strobes. Node writes already issued are not undone.
- Write outputs are combinational from state/cursor; wr_play is high only in FLIP and PLACE.
- start while busy=1 is ignored. start in the DONE cycle is also ignored; a new move is accepted on the first IDLE cycle.
- Latency from start to done: 1 (CHECK) + sum over the 8 directions of (scan cycles + flips + 1 NEXT_DIR) + 1 (PLACE, legal only) + 1 (DONE).
- A non-ENABLE origin gives done exactly 2 cycles after start (CHECK, DONE).

## Test plan

- Origin BLACK, start → done at cycle start+2, legal=0, flip_count=0, wr_play never high.
- Standard opening: d4/e5 WHITE, d5/e4 BLACK, target (2,3) ENABLE, BLACK mover → exactly one reverse at addr 27, then play at addr 19 with wr_black=1; legal=1, flip_count=1.
- Origin (0,0) ENABLE, rows of WHITE at (0,1..6) and BLACK at (0,7), BLACK mover → six reverse strobes at addr 1..6 in order, N and NE rays out-of-board with no read beyond the edge, flip_count=6.
- Ray W,W,B,EMPTY east plus a W,W,W,edge ray south, BLACK mover → two flips east only, south unflipped, legal=1, flip_count=2.
- ENABLE origin with no bracketed ray, all eight directions scanned → legal=0, no strobes, busy drops after DONE.
- Assert resetn during FLIP after 1 of 3 strobes → outputs return to reset values next edge, no PLACE strobe. A following start completes normally.
